// File: rtl/pe_mac_stream_pkg.sv
// Shared widths and saturation helpers for the streaming PE multiply-accumulate.
// Helpers work on 32-bit signed values, so DATA_W must stay at or below 16.
package pe_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT  = 8;

    function automatic logic signed [31:0] sat_max(input int width);
        return (32'sd1 <<< (width - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int width);
        return -(32'sd1 <<< (width - 1));
    endfunction

    function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] value,
                                                     input int width);
        if (value > sat_max(width)) begin
            return sat_max(width);
        end else if (value < sat_min(width)) begin
            return sat_min(width);
        end
        return value;
    endfunction

    function automatic logic signed [31:0] relu(input logic signed [31:0] value);
        return (value < 0) ? 32'sd0 : value;
    endfunction

endpackage

// File: rtl/pe_mac_stream_if.sv
// Operand and result streams of the PE MAC; master is the feeder/collector side.
interface pe_mac_stream_if
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_f;
    logic signed [DATA_W-1:0] in_w;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic [CNT_W-1:0]         out_count;

    modport master (
        output in_valid, in_f, in_w, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_f, in_w, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_count
    );

endinterface

// File: rtl/pe_mac_stream_sat_mult.sv
// Combinational signed multiply at full 2*DATA_W width, clamped back to DATA_W.
module pe_sat_mult
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] product,
    output logic                     clamped
);

    logic signed [2*DATA_W-1:0] full;

    always_comb begin
        full    = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        product = DATA_W'(sat_clamp(32'(full), DATA_W));
        clamped = (sat_clamp(32'(full), DATA_W) != 32'(full));
    end

endmodule

// File: rtl/pe_mac_stream.sv
// Two-stage streaming MAC: stage 1 multiplies, stage 2 accumulates a group and
// loads one saturated (optionally ReLU'd) result per in_last-delimited group.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    input  logic           relu_en,
    pe_mac_stream_if.slave bus
);

    logic stall;
    logic accept;
    logic advance;
    logic load_out;

    logic signed [DATA_W-1:0] mult_prod;
    logic                     mult_clamped;

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_prod;
    logic                     s1_psat;
    logic                     s1_last;

    logic                     first;
    logic signed [DATA_W-1:0] acc;
    logic                     grp_sat;
    logic [CNT_W-1:0]         cnt;

    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W:0]   sum_wide;
    logic signed [DATA_W-1:0] sum_sat;
    logic                     sum_ovf;
    logic                     grp_sat_next;
    logic [CNT_W-1:0]         cnt_next;
    logic signed [DATA_W-1:0] result;

    // A held result freezes the whole pipe; flush only blocks new beats and stage 2.
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~flush;
    assign accept       = bus.in_valid & bus.in_ready;
    assign advance      = s1_valid & ~stall & ~flush;
    assign load_out     = advance & s1_last;

    pe_sat_mult #(.DATA_W(DATA_W)) u_mult (
        .a       (bus.in_f),
        .b       (bus.in_w),
        .product (mult_prod),
        .clamped (mult_clamped)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_psat  <= 1'b0;
            s1_last  <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_prod <= mult_prod;
                s1_psat <= mult_clamped;
                s1_last <= bus.in_last;
            end
        end
    end

    always_comb begin
        base         = first ? '0 : acc;
        sum_wide     = {base[DATA_W-1], base} + {s1_prod[DATA_W-1], s1_prod};
        sum_sat      = DATA_W'(sat_clamp(32'(sum_wide), DATA_W));
        sum_ovf      = (sat_clamp(32'(sum_wide), DATA_W) != 32'(sum_wide));
        grp_sat_next = (first ? 1'b0 : grp_sat) | s1_psat | sum_ovf;
        if (first) begin
            cnt_next = CNT_W'(1);
        end else if (&cnt) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
        result = relu_en ? DATA_W'(relu(32'(sum_sat))) : sum_sat;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first   <= 1'b1;
            acc     <= '0;
            grp_sat <= 1'b0;
            cnt     <= '0;
        end else if (flush) begin
            first   <= 1'b1;
            acc     <= '0;
            grp_sat <= 1'b0;
            cnt     <= '0;
        end else if (advance) begin
            first   <= s1_last;
            acc     <= sum_sat;
            grp_sat <= grp_sat_next;
            cnt     <= cnt_next;
        end
    end

    // Loading and releasing on the same edge keeps out_valid high for full throughput.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_count <= '0;
        end else if (load_out) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= result;
            bus.out_sat   <= grp_sat_next;
            bus.out_count <= cnt_next;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
